ysyx_24100029_mem_arbiter: RTL and testbench

YSYX_24100029_MEM_ARBITER -- requirements
Module: ysyx_24100029_mem_arbiter

---
 rtl/ysyx_24100029_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ysyx_24100029_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_24100029_mem_arbiter
//
// Purpose:
//   Two-master (IFU = bit0, LSU = bit1) to one-slave memory arbiter. The
//   arbiter allows at most one transaction in flight. Each transaction runs
//   through three phases: arbitration, then the request handshake, then the
//   response handshake.
//
// Configuration:
//   YSYX_24100029_ARB_RR_EN  defined   -> round-robin between the two masters
//                            undefined -> fixed priority, LSU over IFU
//
// Ports:
//   clock, reset_n        sole clock (rising edge), async active-low reset
//   m_req_*               per-master request channels (master i packed at
//                         [i*W +: W]); m_req_ready is driven only to the
//                         granted master
//   m_resp_*              per-master response channels; rdata is shared
//   s_req_*               single memory-side request channel
//   s_resp_*              single memory-side response channel
//   grant                 one-hot owner of the slave port, 0 when idle
//
// States:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no owner; arbitrate any pending request into grant
//   ST_REQ  | granted master's request forwarded to the slave
//   ST_RESP | slave response routed back to the granted master
// ----------------------------------------------------------------------------
module ysyx_24100029_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [1:0]              m_req_valid,
  output logic [1:0]              m_req_ready,
  input  logic [2*ADDR_W-1:0]     m_req_addr,
  input  logic [1:0]              m_req_wen,
  input  logic [2*DATA_W-1:0]     m_req_wdata,
  input  logic [2*(DATA_W/8)-1:0] m_req_wstrb,
  output logic [1:0]              m_resp_valid,
  input  logic [1:0]              m_resp_ready,
  output logic [DATA_W-1:0]       m_resp_rdata,
  output logic                    s_req_valid,
  input  logic                    s_req_ready,
  output logic [ADDR_W-1:0]       s_req_addr,
  output logic                    s_req_wen,
  output logic [DATA_W-1:0]       s_req_wdata,
  output logic [DATA_W/8-1:0]     s_req_wstrb,
  input  logic                    s_resp_valid,
  output logic                    s_resp_ready,
  input  logic [DATA_W-1:0]       s_resp_rdata,
  output logic [1:0]              grant
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_grant;
  logic [1:0]  w_grant_nxt;
  logic [1:0]  w_winner;
  logic        w_sel;
  logic        w_req_fire;
  logic        w_resp_done;

  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [STRB_W-1:0] w_sel_wstrb;
  logic              w_sel_wen;

  // grant is one-hot in REQ/RESP, so bit1 alone selects the owner's lane
  assign w_sel       = r_grant[1];
  assign w_sel_addr  = w_sel ? m_req_addr[2*ADDR_W-1:ADDR_W]  : m_req_addr[ADDR_W-1:0];
  assign w_sel_wdata = w_sel ? m_req_wdata[2*DATA_W-1:DATA_W] : m_req_wdata[DATA_W-1:0];
  assign w_sel_wstrb = w_sel ? m_req_wstrb[2*STRB_W-1:STRB_W] : m_req_wstrb[STRB_W-1:0];
  assign w_sel_wen   = w_sel ? m_req_wen[1] : m_req_wen[0];

  assign w_req_fire  = (r_state == ST_REQ)  && s_req_valid  && s_req_ready;
  assign w_resp_done = (r_state == ST_RESP) && s_resp_valid && s_resp_ready;

`ifdef YSYX_24100029_ARB_RR_EN
  // r_ptr names the master favoured on the next tie (0 = IFU). It is loaded
  // with the opposite of the master that just finished, so the previous
  // winner loses the next tie.
  logic r_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= 1'b0;
    end else if (w_resp_done) begin
      r_ptr <= r_grant[0];
    end
  end

  always_comb begin
    w_winner = m_req_valid;
    if (m_req_valid == 2'b11) begin
      w_winner = r_ptr ? 2'b10 : 2'b01;
    end
  end
`else
  always_comb begin
    w_winner = 2'b00;
    if (m_req_valid[1]) begin
      w_winner = 2'b10;
    end else if (m_req_valid[0]) begin
      w_winner = 2'b01;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (|m_req_valid) begin
          w_state_nxt = ST_REQ;
          w_grant_nxt = w_winner;
        end
      end
      ST_REQ: begin
        if (w_req_fire) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_resp_done) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 2'b00;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  // Outputs are pure functions of state so an async reset zeroes them at once.
  // Data buses are forced to 0 outside their phase rather than left floating.
  always_comb begin
    s_req_valid  = 1'b0;
    s_req_addr   = '0;
    s_req_wen    = 1'b0;
    s_req_wdata  = '0;
    s_req_wstrb  = '0;
    m_req_ready  = 2'b00;
    s_resp_ready = 1'b0;
    m_resp_valid = 2'b00;
    m_resp_rdata = '0;
    case (r_state)
      ST_REQ: begin
        s_req_valid = |(r_grant & m_req_valid);
        s_req_addr  = w_sel_addr;
        s_req_wen   = w_sel_wen;
        s_req_wdata = w_sel_wdata;
        s_req_wstrb = w_sel_wstrb;
        m_req_ready = r_grant & {2{s_req_ready}};
      end
      ST_RESP: begin
        s_resp_ready = |(r_grant & m_resp_ready);
        m_resp_valid = r_grant & {2{s_resp_valid}};
        m_resp_rdata = s_resp_rdata;
      end
      default: begin
      end
    endcase
  end

  assign grant = r_grant;

endmodule

// File: tb/tb_ysyx_24100029_mem_arbiter.sv
module tb_ysyx_24100029_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int NV = 8;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [1:0]      m_req_valid;
  logic [1:0]      m_req_ready;
  logic [2*AW-1:0] m_req_addr;
  logic [1:0]      m_req_wen;
  logic [2*DW-1:0] m_req_wdata;
  logic [2*SW-1:0] m_req_wstrb;
  logic [1:0]      m_resp_valid;
  logic [1:0]      m_resp_ready;
  logic [DW-1:0]   m_resp_rdata;
  logic            s_req_valid;
  logic            s_req_ready;
  logic [AW-1:0]   s_req_addr;
  logic            s_req_wen;
  logic [DW-1:0]   s_req_wdata;
  logic [SW-1:0]   s_req_wstrb;
  logic            s_resp_valid;
  logic            s_resp_ready;
  logic [DW-1:0]   s_resp_rdata;
  logic [1:0]      grant;

  ysyx_24100029_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_req_addr   (m_req_addr),
    .m_req_wen    (m_req_wen),
    .m_req_wdata  (m_req_wdata),
    .m_req_wstrb  (m_req_wstrb),
    .m_resp_valid (m_resp_valid),
    .m_resp_ready (m_resp_ready),
    .m_resp_rdata (m_resp_rdata),
    .s_req_valid  (s_req_valid),
    .s_req_ready  (s_req_ready),
    .s_req_addr   (s_req_addr),
    .s_req_wen    (s_req_wen),
    .s_req_wdata  (s_req_wdata),
    .s_req_wstrb  (s_req_wstrb),
    .s_resp_valid (s_resp_valid),
    .s_resp_ready (s_resp_ready),
    .s_resp_rdata (s_resp_rdata),
    .grant        (grant)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    valid;
    logic [1:0]    wen;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [SW-1:0] wstrb0;
    logic [SW-1:0] wstrb1;
    int            req_dly;
    int            bp;
    logic [DW-1:0] rdata;
  } vec_t;

  typedef struct {
    logic [1:0]    g;
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[NV];
  int   n_pass = 0;
  int   n_total = 0;
  logic m_fav = 1'b0;  // reference tie-break: 1 = LSU wins the next tie

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [1:0] model_arb(input logic [1:0] v);
`ifdef YSYX_24100029_ARB_RR_EN
    if (v == 2'b11) return m_fav ? 2'b10 : 2'b01;
    return v;
`else
    if (v[1]) return 2'b10;
    return v[0] ? 2'b01 : 2'b00;
`endif
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"},    64'(grant),        64'(0));
    chk({tag, "_sreqv"},    64'(s_req_valid),  64'(0));
    chk({tag, "_sresprdy"}, 64'(s_resp_ready), 64'(0));
    chk({tag, "_mreqrdy"},  64'(m_req_ready),  64'(0));
    chk({tag, "_mrespv"},   64'(m_resp_valid), 64'(0));
    chk({tag, "_saddr"},    64'(s_req_addr),   64'(0));
    chk({tag, "_rdata"},    64'(m_resp_rdata), 64'(0));
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 in IDLE.
  task automatic run_txn(input vec_t v, input int idx);
    exp_t  e;
    exp_t  e2;
    int    n;
    string t;
    t = $sformatf("t%0d", idx);
    m_req_valid = v.valid;
    m_req_addr  = {v.addr1, v.addr0};
    m_req_wen   = v.wen;
    m_req_wdata = {v.wdata1, v.wdata0};
    m_req_wstrb = {v.wstrb1, v.wstrb0};
    e.g     = model_arb(v.valid);
    e.addr  = e.g[1] ? v.addr1  : v.addr0;
    e.wen   = e.g[1] ? v.wen[1] : v.wen[0];
    e.wdata = e.g[1] ? v.wdata1 : v.wdata0;
    e.wstrb = e.g[1] ? v.wstrb1 : v.wstrb0;
    e.rdata = v.rdata;
    sb.push_back(e);
    n = 0;
    #1;
    chk({t, "_idle_grant"}, 64'(grant), 64'(0));
    @(posedge clock); #1; n++;
    chk({t, "_grant"}, 64'(grant), 64'(e.g));
    for (int i = 0; i < v.req_dly; i++) begin
      chk({t, "_stall_sreqv"}, 64'(s_req_valid), 64'(1));
      chk({t, "_stall_mreqrdy"}, 64'(m_req_ready), 64'(0));
      chk({t, "_stall_saddr"}, 64'(s_req_addr), 64'(e.addr));
      chk({t, "_stall_swdata"}, 64'(s_req_wdata), 64'(e.wdata));
      @(posedge clock); #1; n++;
    end
    s_req_ready = 1'b1;
    #1;
    chk({t, "_mreqrdy"}, 64'(m_req_ready), 64'(e.g));
    chk({t, "_saddr"},   64'(s_req_addr),  64'(e.addr));
    chk({t, "_swen"},    64'(s_req_wen),   64'(e.wen));
    chk({t, "_swdata"},  64'(s_req_wdata), 64'(e.wdata));
    chk({t, "_swstrb"},  64'(s_req_wstrb), 64'(e.wstrb));
    chk({t, "_sresprdy_req"}, 64'(s_resp_ready), 64'(0));
    @(posedge clock); #1; n++;
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b1;
    s_resp_rdata = v.rdata;
    m_resp_ready = 2'b00;
    #1;
    for (int i = 0; i < v.bp; i++) begin
      chk({t, "_bp_sresprdy"}, 64'(s_resp_ready), 64'(0));
      chk({t, "_bp_grant"},    64'(grant),        64'(e.g));
      chk({t, "_bp_sreqv"},    64'(s_req_valid),  64'(0));
      chk({t, "_bp_mrespv"},   64'(m_resp_valid), 64'(e.g));
      @(posedge clock); #1; n++;
    end
    m_resp_ready = 2'b11;
    #1;
    if (sb.size() == 0) begin
      chk({t, "_sb_nonempty"}, 64'(0), 64'(1));
    end else begin
      e2 = sb.pop_front();
      chk({t, "_mrespv"},   64'(m_resp_valid), 64'(e2.g));
      chk({t, "_rdata"},    64'(m_resp_rdata), 64'(e2.rdata));
      chk({t, "_sresprdy"}, 64'(s_resp_ready), 64'(1));
    end
    @(posedge clock); #1; n++;
    s_resp_valid = 1'b0;
    m_resp_ready = 2'b00;
    chk({t, "_done_grant"}, 64'(grant), 64'(0));
    chk({t, "_cycles"}, 64'(n), 64'(3 + v.req_dly + v.bp));
    m_fav = e.g[0];
  endtask

  initial begin
    vec_t pv;
    m_req_valid  = 2'b00;
    m_req_addr   = '0;
    m_req_wen    = 2'b00;
    m_req_wdata  = '0;
    m_req_wstrb  = '0;
    m_resp_ready = 2'b00;
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b0;
    s_resp_rdata = '0;

    // valid, wen, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1, req_dly, bp, rdata
    vecs[0] = '{2'b11, 2'b10, 32'h8000_1000, 32'h9000_2000, 32'h0101_0101, 32'h0202_0202, 4'hC, 4'h5, 0, 0, 32'h3000_0001};
    vecs[1] = '{2'b11, 2'b10, 32'h8000_1004, 32'h9000_2004, 32'h0303_0303, 32'h0404_0404, 4'hC, 4'h5, 0, 0, 32'h3000_0002};
    vecs[2] = '{2'b11, 2'b01, 32'h8000_1008, 32'h9000_2008, 32'h0505_0505, 32'h0606_0606, 4'h3, 4'hA, 1, 1, 32'h3000_0003};
    vecs[3] = '{2'b11, 2'b00, 32'h8000_100C, 32'h9000_200C, 32'h0707_0707, 32'h0808_0808, 4'h1, 4'h8, 0, 0, 32'h3000_0004};
    vecs[4] = '{2'b01, 2'b00, 32'h8000_0000, 32'h8000_0004, 32'h0000_0000, 32'h0000_0000, 4'h0, 4'h0, 0, 0, 32'hDEAD_BEEF};
    vecs[5] = '{2'b10, 2'b10, 32'h8000_0020, 32'h8000_0010, 32'hAAAA_5555, 32'h1234_5678, 4'h3, 4'hF, 4, 0, 32'h0000_0000};
    vecs[6] = '{2'b01, 2'b01, 32'h8000_0100, 32'h0000_0000, 32'h0BAD_F00D, 32'h0000_0000, 4'h1, 4'h0, 0, 3, 32'h1111_2222};
    vecs[7] = '{2'b10, 2'b00, 32'h8000_0200, 32'h8000_0040, 32'h0000_0000, 32'hFFFF_0000, 4'h0, 4'h6, 2, 2, 32'h7777_8888};

    #1;
    chk_quiet("rst");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_quiet("idle_norq");

    for (int i = 0; i < NV; i++) run_txn(vecs[i], i);
    m_req_valid = 2'b00;

    // Reset while in RESP: everything drops in the same cycle, no response later.
    m_req_valid = 2'b01;
    @(posedge clock); #1;
    s_req_ready = 1'b1;
    @(posedge clock); #1;
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b1;
    s_resp_rdata = 32'hBAD0_BAD0;
    m_resp_ready = 2'b00;
    #1;
    chk("mid_resp_grant", 64'(grant), 64'(1));
    chk("mid_resp_mrespv", 64'(m_resp_valid), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    m_fav = 1'b0;
    sb.delete();
    m_resp_ready = 2'b11;
    @(posedge clock); #1;
    chk_quiet("held_rst");
    reset_n = 1'b1;
    #1;
    chk("post_rst_mrespv", 64'(m_resp_valid), 64'(0));
    chk("post_rst_sresprdy", 64'(s_resp_ready), 64'(0));
    s_resp_valid = 1'b0;
    m_resp_ready = 2'b00;

`ifdef YSYX_24100029_ARB_RR_EN
    pv = '{2'b11, 2'b00, 32'h8000_0300, 32'h9000_0300, 32'h0, 32'h0, 4'h0, 4'h0, 0, 0, 32'hCAFE_F00D};
`else
    pv = '{2'b01, 2'b00, 32'h8000_0300, 32'h9000_0300, 32'h0, 32'h0, 4'h0, 4'h0, 0, 0, 32'hCAFE_F00D};
`endif
    run_txn(pv, 99);
    m_req_valid = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
